// File: rtl/reg_file_scan_if.sv
// Register-file access bus: two read ports and one write port.
// The datapath drives addresses and write data; the register file returns read data.
interface reg_file_scan_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             RegWe;
  logic [AW-1:0]    Rw;
  logic [WIDTH-1:0] WD;
  logic [AW-1:0]    Rs1;
  logic [AW-1:0]    Rs2;
  logic [WIDTH-1:0] Rd1;
  logic [WIDTH-1:0] Rd2;

  modport master (
    output RegWe, Rw, WD, Rs1, Rs2,
    input  Rd1, Rd2
  );

  modport slave (
    input  RegWe, Rw, WD, Rs1, Rs2,
    output Rd1, Rd2
  );
endinterface

// File: rtl/reg_file_scan.sv
// Parametrised 2R1W register file with optional hard-zero R0, optional write forwarding,
// and a full-depth serial scan chain with a wrapping shift counter.
module reg_file_scan #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 0
) (
  input  logic                              Clock,
  input  logic                              Reset,
  reg_file_scan_if.slave                    bus,
  input  logic                              Test,
  input  logic                              SDI,
  output logic                              SDO,
  output logic [$clog2(WIDTH*DEPTH):0]      ScanCount,
  output logic                              ScanWrap
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH*DEPTH) + 1;
  localparam int LO = (ZERO_R0 != 0) ? 1 : 0;
  localparam int L  = WIDTH * (DEPTH - LO);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] shiftIn;
  logic             writeOk;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // Bit entering each register's MSB during a shift: SDI at the top, else the LSB of the register above.
  always_comb begin
    shiftIn = '0;
    shiftIn[DEPTH-1] = SDI;
    for (int i = 0; i < DEPTH - 1; i++) shiftIn[i] = regs[i+1][0];
  end

  assign writeOk = bus.RegWe && !Test && !((ZERO_R0 != 0) && (bus.Rw == '0));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      ScanCount <= '0;
      ScanWrap  <= 1'b0;
    end else begin
      ScanWrap <= 1'b0;
      if (Test) begin
        for (int i = LO; i < DEPTH; i++) regs[i] <= {shiftIn[i], regs[i][WIDTH-1:1]};
        if (ScanCount == CW'(L - 1)) begin
          ScanCount <= '0;
          ScanWrap  <= 1'b1;
        end else begin
          ScanCount <= ScanCount + CW'(1);
        end
      end else if (writeOk) begin
        regs[bus.Rw] <= bus.WD;
      end
    end
  end

  // Hard-zero R0 takes precedence over forwarding so a write to R0 never leaks through.
  always_comb begin
    rd1 = regs[bus.Rs1];
    rd2 = regs[bus.Rs2];
    if ((BYPASS != 0) && writeOk && (bus.Rw == bus.Rs1)) rd1 = bus.WD;
    if ((BYPASS != 0) && writeOk && (bus.Rw == bus.Rs2)) rd2 = bus.WD;
    if ((ZERO_R0 != 0) && (bus.Rs1 == '0)) rd1 = '0;
    if ((ZERO_R0 != 0) && (bus.Rs2 == '0)) rd2 = '0;
  end

  assign bus.Rd1 = rd1;
  assign bus.Rd2 = rd2;
  assign SDO     = regs[LO][0];
endmodule

// File: tb/tb_reg_file_scan.sv
// Directed bench for reg_file_scan: default instance for read/write/scan,
// second instance with hard-zero R0 and forwarding enabled.
module tb_reg_file_scan;
  logic       Clock = 1'b0;
  logic       Reset;
  logic       Test, SDI, testZb, sdiZb;
  logic       SDO, ScanWrap, sdoZb, scanWrapZb;
  logic [7:0] ScanCount, scanCountZb;

  int nChecks = 0;
  int nPass   = 0;
  int wrapSeen;
  logic [15:0]  rdVal;
  logic [127:0] chain;

  reg_file_scan_if #(.WIDTH(16), .DEPTH(8)) bus ();
  reg_file_scan_if #(.WIDTH(16), .DEPTH(8)) busZb ();

  reg_file_scan #(.WIDTH(16), .DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus.slave), .Test(Test), .SDI(SDI),
    .SDO(SDO), .ScanCount(ScanCount), .ScanWrap(ScanWrap)
  );

  reg_file_scan #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1), .BYPASS(1)) dutZb (
    .Clock(Clock), .Reset(Reset), .bus(busZb.slave), .Test(testZb), .SDI(sdiZb),
    .SDO(sdoZb), .ScanCount(scanCountZb), .ScanWrap(scanWrapZb)
  );

  always #10 Clock = ~Clock;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [15:0] v);
    bus.Rs1 = a;
    #1;
    v = bus.Rd1;
  endtask

  initial begin
    Reset = 1'b1; Test = 1'b0; SDI = 1'b0; testZb = 1'b0; sdiZb = 1'b0;
    bus.RegWe = 1'b0; bus.Rw = '0; bus.WD = '0; bus.Rs1 = '0; bus.Rs2 = '0;
    busZb.RegWe = 1'b0; busZb.Rw = '0; busZb.WD = '0; busZb.Rs1 = '0; busZb.Rs2 = '0;
    step(); step();
    Reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      bus.Rs1 = 3'(a); bus.Rs2 = 3'(a);
      #1;
      checkEq($sformatf("reset_rd1_r%0d", a), 32'(bus.Rd1), 32'h0);
      checkEq($sformatf("reset_rd2_r%0d", a), 32'(bus.Rd2), 32'h0);
    end
    checkEq("reset_sdo", 32'(SDO), 32'h0);
    checkEq("reset_count", 32'(ScanCount), 32'h0);
    checkEq("reset_wrap", 32'(ScanWrap), 32'h0);

    // Basic writes, no forwarding on the default instance
    bus.RegWe = 1'b1; bus.Rw = 3'd3; bus.WD = 16'h1234;
    step();
    bus.Rw = 3'd7; bus.WD = 16'hBEEF; bus.Rs2 = 3'd7;
    #1;
    checkEq("no_bypass_before_edge", 32'(bus.Rd2), 32'h0);
    step();
    bus.RegWe = 1'b0; bus.Rs1 = 3'd3; bus.Rs2 = 3'd7;
    #1;
    checkEq("write_r3", 32'(bus.Rd1), 32'h1234);
    checkEq("write_r7", 32'(bus.Rd2), 32'hBEEF);
    bus.Rw = 3'd3; bus.WD = 16'hFFFF;
    step();
    checkEq("regwe_low_hold", 32'(bus.Rd1), 32'h1234);

    // Hard-zero R0 and forwarding
    busZb.RegWe = 1'b1; busZb.Rw = 3'd0; busZb.WD = 16'hFFFF; busZb.Rs1 = 3'd0;
    #1;
    checkEq("zb_r0_bypass_zero", 32'(busZb.Rd1), 32'h0);
    step();
    busZb.RegWe = 1'b0;
    #1;
    checkEq("zb_r0_reads_zero", 32'(busZb.Rd1), 32'h0);
    busZb.RegWe = 1'b1; busZb.Rw = 3'd5; busZb.Rs1 = 3'd5; busZb.Rs2 = 3'd5; busZb.WD = 16'hA5A5;
    #1;
    checkEq("zb_bypass_rd1", 32'(busZb.Rd1), 32'hA5A5);
    checkEq("zb_bypass_rd2", 32'(busZb.Rd2), 32'hA5A5);
    step();
    busZb.RegWe = 1'b0; busZb.WD = 16'h0000;
    #1;
    checkEq("zb_r5_stored", 32'(busZb.Rd1), 32'hA5A5);

    // Full-chain scan: preload R0=1, then shift in 0x8000 for every register
    bus.RegWe = 1'b1; bus.Rw = 3'd0; bus.WD = 16'h0001;
    step();
    bus.RegWe = 1'b0;
    Test = 1'b1; SDI = 1'b0;
    #1;
    checkEq("sdo_before_shift", 32'(SDO), 32'h1);
    wrapSeen = 0;
    for (int k = 0; k < 128; k++) begin
      SDI = ((k % 16) == 15);
      step();
      if (k == 0) begin
        checkEq("sdo_after_shift", 32'(SDO), 32'h0);
        checkEq("count_after_first", 32'(ScanCount), 32'h1);
      end
      if (k < 127) wrapSeen += int'(ScanWrap);
    end
    checkEq("wrap_early", 32'(wrapSeen), 32'h0);
    checkEq("wrap_pulse", 32'(ScanWrap), 32'h1);
    checkEq("count_wrapped", 32'(ScanCount), 32'h0);
    Test = 1'b0; SDI = 1'b0;
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), rdVal);
      checkEq($sformatf("scan_load_r%0d", a), 32'(rdVal), 32'h8000);
    end
    step();
    checkEq("wrap_one_cycle", 32'(ScanWrap), 32'h0);

    // Scan ignores RegWe; partial scan then hold
    chain = {8{16'h8000}};
    Test = 1'b1; bus.RegWe = 1'b1; bus.Rw = 3'd2; bus.WD = 16'h5555; SDI = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chain = {1'b0, chain[127:1]};
    end
    Test = 1'b0; bus.RegWe = 1'b0;
    checkEq("count_40", 32'(ScanCount), 32'd40);
    readReg(3'd2, rdVal);
    checkEq("r2_shift_only", 32'(rdVal), 32'h0080);
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), rdVal);
      checkEq($sformatf("partial_r%0d", a), 32'(rdVal), 32'(chain[16*a +: 16]));
    end
    step(); step();
    checkEq("count_hold", 32'(ScanCount), 32'd40);

    // Resume, then reset mid-scan
    Test = 1'b1; SDI = 1'b1;
    for (int k = 0; k < 10; k++) step();
    checkEq("count_resume", 32'(ScanCount), 32'd50);
    Reset = 1'b1;
    step();
    Reset = 1'b0; Test = 1'b0; SDI = 1'b0;
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), rdVal);
      checkEq($sformatf("midscan_reset_r%0d", a), 32'(rdVal), 32'h0);
    end
    checkEq("midscan_reset_count", 32'(ScanCount), 32'h0);
    checkEq("midscan_reset_wrap", 32'(ScanWrap), 32'h0);
    checkEq("midscan_reset_sdo", 32'(SDO), 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/reg_file_scan.md
Name: reg_file_scan

Overview:
- Parametrised successor of the CPU datapath's fixed 8x16 register bank.
- Generalised in width and depth, with an optional hard-zero R0 and optional write-to-read forwarding.
- Adds a full-depth serial scan chain with a shift counter, so the production test can load and unload every register through SDI/SDO.
- Sits between the datapath's Rs1/Rs2/Rw select muxes and the operand muxes.

Parameters:
- WIDTH, 16, register width in bits (>=2).
- DEPTH, 8, number of registers (power of two, >=2).
- AW, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_R0, 0: 1 = register 0 reads as zero, ignores writes and is excluded from the scan chain.
- BYPASS, 0: 1 = a read of the register being written this cycle returns WD combinationally.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- RegWe  in  1  write enable.
- Rw  in  AW  write address.
- WD  in  WIDTH  write data.
- Rs1  in  AW  read address, port 1.
- Rs2  in  AW  read address, port 2.
- Rd1  out  WIDTH  read data, port 1.
- Rd2  out  WIDTH  read data, port 2.
- Test  in  1  scan mode; shifts the chain one bit per cycle.
- SDI  in  1  scan serial input.
- SDO  out  1  scan serial output.
- ScanCount  out  $clog2(WIDTH*DEPTH)+1  bits shifted since the last wrap or reset.
- ScanWrap  out  1  one-cycle pulse when a full chain length has been shifted.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high. At a rising edge with Reset=1:
  - all registers, ScanCount and ScanWrap go to 0;
  - Reset overrides Test and RegWe, including mid-scan; a partial scan is discarded.
- Reads: Rd1 = reg[Rs1] and Rd2 = reg[Rs2], combinational, zero latency.
  - ZERO_R0=1 and address 0: output is 0.
  - BYPASS=1, RegWe=1, Test=0, and Rw equal to the read address (non-zero when ZERO_R0=1): output = WD.
  - BYPASS=0: the new value is visible the cycle after the write edge.
- Writes: on the edge with RegWe=1 and Test=0, reg[Rw] <= WD.
  - Write to R0 with ZERO_R0=1: no effect.
  - RegWe is ignored while Test=1.
- Scan chain:
  - Chain length L = WIDTH*DEPTH, or WIDTH*(DEPTH-1) when ZERO_R0=1.
  - Order, MSB to LSB: reg[DEPTH-1][WIDTH-1] ... reg[lowest scanned][0].
  - Each edge with Test=1: the chain shifts right one bit. SDI enters reg[DEPTH-1][WIDTH-1]. Each register's bit 0 moves into bit WIDTH-1 of the next-lower scanned register.
  - SDO = bit 0 of the lowest scanned register (reg[0], or reg[1] when ZERO_R0=1). SDO is combinational from state and valid in both modes.
  - Rd1/Rd2 track register contents during the shift.
- Scan counter:
  - Increments on each Test=1 edge.
  - On the edge where it would reach L it wraps to 0 and ScanWrap=1 for the following cycle; ScanWrap is otherwise 0.
  - Holds its value when Test=0; is not cleared by leaving test mode.
  - Test may drop and rise mid-chain; shifting resumes where it stopped.
- Simultaneous events: Reset > Test > RegWe.

Test Plan:
- Reset, then read all addresses -> Rd1=Rd2=0x0000; SDO=0; ScanCount=0; ScanWrap=0.
- Defaults: write 0x1234 to R3, then 0xBEEF to R7 -> next cycle Rs1=3 gives 0x1234 and Rs2=7 gives 0xBEEF. A write to R3 with RegWe=0 leaves 0x1234.
- ZERO_R0=1: write 0xFFFF to R0 -> Rd1=0 at Rs1=0. BYPASS=1: RegWe=1, Rw=Rs1=5, WD=0xA5A5 -> Rd1=0xA5A5 in the same cycle, before the edge.
- Defaults: preload R0=0x0001, then Test=1 with SDI=0 -> SDO=1 before the first edge, 0 after it. Continue 128 shifts of the pattern 0x8000 repeated per register -> every register reads 0x8000. ScanWrap is high exactly once, on the cycle after the 128th edge; ScanCount reads 0.
- Test=1 with RegWe=1, Rw=2, WD=0x5555 -> R2 unchanged by the write, only shifted. Drop Test after 40 shifts -> ScanCount holds 40.
- Assert Reset after 50 shifts with Test=1 -> all registers 0, ScanCount=0, ScanWrap=0 on the next cycle.
